// File: rtl/fft_magnitude_21bit.sv
// Pipelined floor(sqrt(re^2 + im^2)) for the FFT source stream; LATENCY cycles from valid_in to valid_out.
// One sample per clock with no backpressure; magnitude_out holds its value between results.
module fft_magnitude_21bit #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  real_in,
  input  logic [IN_W-1:0]  imag_in,
  input  logic             valid_in,
  output logic [OUT_W-1:0] magnitude_out,
  output logic             valid_out
);

  localparam int LATENCY = IN_W + 2;
  localparam int SQ_W    = 2 * IN_W;
  // remainder stays below 2*root+1 < 2^(IN_W+1); two extra bits absorb the per-stage shift
  localparam int REM_W   = IN_W + 3;

  // ---------------------------------------------------------------- squares
  logic [SQ_W-1:0] re_ext;
  logic [SQ_W-1:0] im_ext;
  logic [SQ_W-1:0] re_sq;
  logic [SQ_W-1:0] im_sq;

  // sign-extended operands make the low SQ_W bits of the product the exact square
  assign re_ext = {{IN_W{real_in[IN_W-1]}}, real_in};
  assign im_ext = {{IN_W{imag_in[IN_W-1]}}, imag_in};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  logic [SQ_W-1:0] re_sq_q;
  logic [SQ_W-1:0] im_sq_q;
  logic [SQ_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    re_sq_q <= re_sq;
    im_sq_q <= im_sq;
    sum_q   <= re_sq_q + im_sq_q;
  end

  // ---------------------------------------------------------------- valid pipe
  logic [LATENCY-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], valid_in};
    end
  end

  // ---------------------------------------------------------------- square root
  logic [REM_W-1:0] rem_q  [IN_W];
  logic [IN_W-1:0]  root_q [IN_W];
  logic [SQ_W-1:0]  rad_q  [IN_W];

  for (genvar g = 0; g < IN_W; g++) begin : g_sqrt
    logic [REM_W-1:0] rem_prev;
    logic [IN_W-1:0]  root_prev;
    logic [SQ_W-1:0]  rad_prev;
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] trial;
    logic             take;

    if (g == 0) begin : g_first
      assign rem_prev  = '0;
      assign root_prev = '0;
      assign rad_prev  = sum_q;
    end else begin : g_next
      assign rem_prev  = rem_q[g-1];
      assign root_prev = root_q[g-1];
      assign rad_prev  = rad_q[g-1];
    end

    // bring down the next two radicand bits, MSB pair first
    assign rem_sh = (rem_prev << 2) | REM_W'(rad_prev[SQ_W-1 -: 2]);
    assign trial  = {1'b0, root_prev, 2'b01};
    assign take   = (rem_sh >= trial);

    always_ff @(posedge clk) begin
      rem_q[g]  <= take ? (rem_sh - trial) : rem_sh;
      root_q[g] <= (root_prev << 1) | IN_W'(take);
      rad_q[g]  <= rad_prev << 2;
    end
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out     <= 1'b0;
      magnitude_out <= '0;
    end else begin
      valid_out <= vld_q[LATENCY-1];
      if (vld_q[LATENCY-1]) begin
        magnitude_out <= {{(OUT_W-IN_W){1'b0}}, root_q[IN_W-1]};
      end
    end
  end

endmodule

// File: tb/tb_fft_magnitude_21bit.sv
// Bench for fft_magnitude_21bit: directed spec vectors plus a randomized stream
// checked every cycle against a floor(sqrt) reference and a due-cycle queue.
module tb_fft_magnitude_21bit;

  localparam int IN_W  = 20;
  localparam int OUT_W = 21;
  localparam int LAT   = 22;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  real_in;
  logic [IN_W-1:0]  imag_in;
  logic             valid_in;
  logic [OUT_W-1:0] magnitude_out;
  logic             valid_out;

  fft_magnitude_21bit dut (
    .clk           (clk),
    .rst           (rst),
    .real_in       (real_in),
    .imag_in       (imag_in),
    .valid_in      (valid_in),
    .magnitude_out (magnitude_out),
    .valid_out     (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint           due;
    logic [OUT_W-1:0] mag;
  } exp_t;

  exp_t             pend[$];
  int               checks = 0;
  int               errors = 0;
  longint           cyc = 0;
  logic [OUT_W-1:0] held = '0;
  logic [OUT_W-1:0] cur_exp;
  int               n_in = 0;
  int               n_out = 0;

  function automatic logic [OUT_W-1:0] ref_mag(int re, int im);
    longint s;
    longint r;
    s = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    r = longint'($floor($sqrt(real'(s))));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return OUT_W'(r);
  endfunction

  task automatic check(string tag, logic [OUT_W-1:0] obs, logic [OUT_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_int(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // drive a sample with an explicit expected magnitude (directed vectors)
  task automatic drive_exp(logic v, int re, int im, int expv);
    valid_in = v;
    real_in  = IN_W'(re);
    imag_in  = IN_W'(im);
    cur_exp  = OUT_W'(expv);
  endtask

  // drive a sample whose expectation comes from the reference model
  task automatic drive_ref(logic v, int re, int im);
    drive_exp(v, re, im, int'(ref_mag(re, im)));
  endtask

  function automatic int rand_s();
    logic signed [IN_W-1:0] t;
    t = IN_W'($urandom);
    return int'(t);
  endfunction

  // one clock: update the model with what the DUT sampled, then check outputs
  task automatic tick();
    exp_t e;
    logic ev;
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
      held = '0;
    end else if (valid_in) begin
      e.due = cyc + LAT;
      e.mag = cur_exp;
      pend.push_back(e);
      n_in++;
    end
    #1;
    ev = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev   = 1'b1;
      held = pend[0].mag;
      void'(pend.pop_front());
    end
    if (valid_out === 1'b1) n_out++;
    check("valid_out", OUT_W'(valid_out), OUT_W'(ev));
    check("magnitude_out", magnitude_out, held);
  endtask

  int vo_seen;

  initial begin
    rst = 1'b1;
    drive_exp(1'b0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // idle after reset: random data, valid low
    for (int i = 0; i < 50; i++) begin
      drive_ref(1'b0, rand_s(), rand_s());
      tick();
    end

    // single sample
    vo_seen = n_out;
    drive_exp(1'b1, 3, 4, 5);
    tick();
    for (int i = 0; i < 30; i++) begin
      drive_ref(1'b0, rand_s(), rand_s());
      tick();
    end
    check_int("single_count", n_out - vo_seen, 1);
    check("single_hold", magnitude_out, OUT_W'(5));

    // back-to-back stream
    drive_exp(1'b1, 0, 0, 0);                  tick();
    drive_exp(1'b1, 1, 1, 1);                  tick();
    drive_exp(1'b1, -1, 0, 1);                 tick();
    drive_exp(1'b1, 524287, 0, 524287);        tick();
    drive_exp(1'b1, -524288, -524288, 741455); tick();
    drive_exp(1'b1, -3, -4, 5);                tick();
    for (int i = 0; i < 26; i++) begin
      drive_ref(1'b0, rand_s(), rand_s());
      tick();
    end

    // gapped stream: magnitude must hold across the gap
    drive_exp(1'b1, 6, 8, 10);  tick();
    drive_ref(1'b0, rand_s(), rand_s()); tick();
    drive_ref(1'b0, rand_s(), rand_s()); tick();
    drive_exp(1'b1, 5, 12, 13); tick();
    for (int i = 0; i < 26; i++) begin
      drive_ref(1'b0, rand_s(), rand_s());
      tick();
    end
    check("gap_last", magnitude_out, OUT_W'(13));

    // reset mid-stream: five in flight are discarded
    vo_seen = n_out;
    for (int i = 0; i < 5; i++) begin
      drive_ref(1'b1, rand_s(), rand_s());
      tick();
    end
    rst = 1'b1;
    drive_ref(1'b1, rand_s(), rand_s());
    tick();
    rst = 1'b0;
    check("after_reset_mag", magnitude_out, OUT_W'(0));
    drive_exp(1'b1, 8, 15, 17);
    tick();
    for (int i = 0; i < 26; i++) begin
      drive_ref(1'b0, rand_s(), rand_s());
      tick();
    end
    check_int("reset_flush_count", n_out - vo_seen, 1);
    check("after_reset_result", magnitude_out, OUT_W'(17));

    // randomized stream with occasional extreme values
    n_in  = 0;
    n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      int re;
      int im;
      re = rand_s();
      im = rand_s();
      if ($urandom_range(15) == 0) re = ($urandom_range(1) == 0) ? -524288 : 524287;
      if ($urandom_range(15) == 0) im = ($urandom_range(1) == 0) ? -524288 : 0;
      drive_ref($urandom_range(3) != 0, re, im);
      tick();
    end
    for (int i = 0; i < 30; i++) begin
      drive_ref(1'b0, rand_s(), rand_s());
      tick();
    end
    check_int("random_count", n_out, n_in);
    check_int("queue_drained", pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
